// File: rtl/rv_pkg.sv
// Shared RV64I pipeline definitions: data widths, the canonical NOP and the
// fetch queue entry layout.
package rv_pkg;

    localparam int XLEN = 64;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Instructions are 4-byte aligned; low address bits are dropped, not trapped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~64'd3;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small in-order FIFO of fetched {pc, instr} pairs. Flush beats push and pop,
// and a push into a full queue is accepted when a pop frees the head the same cycle.
module fetch_queue
    import rv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       wdata,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count,
    output fetch_entry_t       head
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en;
    logic             pop_en;
    logic             wr_en;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[head_q];

    always_comb begin
        pop_en  = pop & ~empty;
        push_en = push & (~full | pop_en);
        wr_en   = push_en & ~flush;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Pointers wrap for free because DEPTH is a power of two.
            if (pop_en)
                head_d = head_q + PTR_W'(1);
            if (push_en)
                tail_d = tail_q + PTR_W'(1);
            if (push_en && !pop_en)
                count_d = count_q + CNT_W'(1);
            else if (pop_en && !push_en)
                count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: empty entries are never presented downstream.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (wr_en && (tail_q == PTR_W'(gi)))
                mem_q[gi] <= wdata;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses the instruction ROM and queues fetched
// words toward decode; execute redirects flush the queue and retarget the PC.
module instr_fetch
    import rv_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [63:0] if_pc4,
    output logic [31:0] if_instr
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [63:0]      pc_q, pc_d;
    logic             push;
    logic             pop;
    logic             q_empty;
    logic             unused_q_full;
    logic [CNT_W-1:0] q_count;
    fetch_entry_t     q_wdata;
    fetch_entry_t     q_head;

    assign imem_addr = pc_q;
    assign pop       = if_valid & if_ready;
    assign q_wdata   = '{pc: pc_q, instr: imem_rd};

    always_comb begin
        push = ~redirect_valid & ((q_count < CNT_W'(DEPTH)) | pop);
        pc_d = pc_q;
        if (redirect_valid)
            pc_d = align_pc(redirect_pc);
        else if (push)
            pc_d = pc_q + 64'd4;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (q_wdata),
        .full  (unused_q_full),
        .empty (q_empty),
        .count (q_count),
        .head  (q_head)
    );

    // Decode sees only registered queue state, never imem_rd or if_ready directly.
    assign if_valid = ~q_empty;
    assign if_pc    = if_valid ? q_head.pc : 64'd0;
    assign if_pc4   = if_valid ? q_head.pc + 64'd4 : 64'd0;
    assign if_instr = if_valid ? q_head.instr : NOP_INSTR;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic, all
// compared against a queue-based reference model of the fetch stage.
module tb_instr_fetch;
    import rv_pkg::*;

    localparam logic [63:0] RST_PC_A = 64'h0;
    localparam logic [63:0] RST_PC_B = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        if_ready = 1'b0;
    logic [63:0] imem_addr, if_pc, if_pc4;
    logic [31:0] imem_rd, if_instr;
    logic        if_valid;

    logic        redirect_valid_b = 1'b0;
    logic [63:0] redirect_pc_b = 64'd0;
    logic        if_ready_b = 1'b1;
    logic [63:0] imem_addr_b, if_pc_b, if_pc4_b;
    logic [31:0] imem_rd_b, if_instr_b;
    logic        if_valid_b;

    logic [31:0] rom [0:1023];

    always #5 clk = ~clk;

    assign imem_rd   = rom[imem_addr[11:2]];
    assign imem_rd_b = rom[imem_addr_b[11:2]];

    instr_fetch #(.RESET_PC(RST_PC_A), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_pc4(if_pc4), .if_instr(if_instr)
    );

    instr_fetch #(.RESET_PC(RST_PC_B), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst(rst), .imem_addr(imem_addr_b), .imem_rd(imem_rd_b),
        .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
        .if_valid(if_valid_b), .if_ready(if_ready_b), .if_pc(if_pc_b),
        .if_pc4(if_pc4_b), .if_instr(if_instr_b)
    );

    fetch_entry_t mq[$];
    logic [63:0]  mpc;
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of the fetch stage at the transaction level.
    task automatic model_step();
        bit do_pop;
        bit do_push;
        if (rst) begin
            mq.delete();
            mpc = RST_PC_A;
        end else if (redirect_valid) begin
            mq.delete();
            mpc = {redirect_pc[63:2], 2'b00};
            $display("redirect to %h", mpc);
        end else begin
            do_pop  = (mq.size() > 0) && if_ready;
            do_push = (mq.size() < DEPTH) || do_pop;
            if (do_pop) begin
                $display("decode pc=%h instr=%h", mq[0].pc, mq[0].instr);
                void'(mq.pop_front());
            end
            if (do_push) begin
                mq.push_back('{pc: mpc, instr: rom[mpc[11:2]]});
                mpc = mpc + 64'd4;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("imem_addr", imem_addr, mpc);
        if (mq.size() > 0) begin
            check_eq("if_valid", {63'd0, if_valid}, 64'd1);
            check_eq("if_pc", if_pc, mq[0].pc);
            check_eq("if_pc4", if_pc4, mq[0].pc + 64'd4);
            check_eq("if_instr", {32'd0, if_instr}, {32'd0, mq[0].instr});
        end else begin
            check_eq("if_valid", {63'd0, if_valid}, 64'd0);
            check_eq("if_pc", if_pc, 64'd0);
            check_eq("if_pc4", if_pc4, 64'd0);
            check_eq("if_instr", {32'd0, if_instr}, {32'd0, NOP_INSTR});
        end
    endtask

    task automatic step(input logic r, input logic rv, input logic [63:0] rpc, input logic rdy);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 1024; i++) rom[i] = i;
        mq.delete();
        mpc = RST_PC_A;

        // Reset, then streaming with decode always ready; wrap instance alongside.
        step(1, 0, 64'd0, 1);
        step(1, 0, 64'd0, 1);
        check_eq("wrap_rst_valid", {63'd0, if_valid_b}, 64'd0);
        check_eq("wrap_rst_addr", imem_addr_b, RST_PC_B);
        check_eq("wrap_rst_instr", {32'd0, if_instr_b}, {32'd0, NOP_INSTR});
        step(0, 0, 64'd0, 1);
        check_eq("wrap_c1_pc", if_pc_b, RST_PC_B);
        check_eq("wrap_c1_pc4", if_pc4_b, 64'd0);
        check_eq("wrap_c1_instr", {32'd0, if_instr_b}, 64'd1023);
        check_eq("wrap_c1_addr", imem_addr_b, 64'd0);
        step(0, 0, 64'd0, 1);
        check_eq("wrap_c2_pc", if_pc_b, 64'd0);
        check_eq("wrap_c2_instr", {32'd0, if_instr_b}, 64'd0);
        repeat (8) step(0, 0, 64'd0, 1);

        // Decode stall for 5 cycles after the first valid, then release.
        step(1, 0, 64'd0, 1);
        step(0, 0, 64'd0, 1);
        repeat (5) step(0, 0, 64'd0, 0);
        check_eq("stall_addr", imem_addr, 64'h8);
        check_eq("stall_pc", if_pc, 64'h0);
        repeat (6) step(0, 0, 64'd0, 1);

        // Misaligned redirect while full, decode stalled.
        repeat (3) step(0, 0, 64'd0, 0);
        step(0, 1, 64'h103, 0);
        check_eq("redir_valid", {63'd0, if_valid}, 64'd0);
        check_eq("redir_addr", imem_addr, 64'h100);
        step(0, 0, 64'd0, 1);
        check_eq("redir_pc", if_pc, 64'h100);
        check_eq("redir_pc4", if_pc4, 64'h104);
        repeat (3) step(0, 0, 64'd0, 1);

        // Redirect coinciding with a pop on a full queue.
        repeat (3) step(0, 0, 64'd0, 0);
        step(0, 1, 64'h200, 1);
        check_eq("redir_pop_valid", {63'd0, if_valid}, 64'd0);
        check_eq("redir_pop_addr", imem_addr, 64'h200);
        repeat (3) step(0, 0, 64'd0, 1);

        // Mid-stream reset once fetch has passed 0x40.
        step(0, 1, 64'h0, 1);
        guard = 0;
        while (mpc != 64'h44 && guard < 40) begin
            step(0, 0, 64'd0, 1);
            guard++;
        end
        check_eq("reach_0x44", mpc, 64'h44);
        step(1, 0, 64'd0, 1);
        check_eq("midrst_valid", {63'd0, if_valid}, 64'd0);
        check_eq("midrst_addr", imem_addr, RST_PC_A);
        repeat (4) step(0, 0, 64'd0, 1);

        // Randomized traffic with a scrambled ROM.
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        for (int n = 0; n < 400; n++) begin
            logic        r, rv, rdy;
            logic [63:0] rpc;
            r   = ($urandom_range(0, 99) < 2);
            rv  = ($urandom_range(0, 99) < 8);
            rdy = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 3) == 0)
                rpc = {$urandom, $urandom};
            else
                rpc = {52'd0, 12'($urandom)};
            step(r, rv, rpc, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
